data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096: number of 32-bit words in the array (power of two).
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response (legal range 1..15).
REQ-003 SHALL have parameter BASE_ADDRESS, default 32'h0000_0000: byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-004 clock  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 loadRequest  input  1  level; held high by the initiator until loadDataValid or until it withdraws (flush).
REQ-007 storeValid  input  1  registered store request; held high until storeComplete is seen.
REQ-008 addressRegister  input  32  byte address of the current access.
REQ-009 storeData  input  32  lane-aligned store data.
REQ-010 realStoreByteEnable  input  4  per-byte write mask, bit i selects storeData[8i+7:8i].
REQ-011 loadData  output  32  full aligned word, valid only while loadDataValid is high.
REQ-012 loadDataValid  output  1  one-cycle load response pulse.
REQ-013 storeComplete  output  1  one-cycle store acknowledge pulse.
REQ-014 accessFault  output  1  pulses with loadDataValid or storeComplete when the access was out of range.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 IDLE: storeValid high -> latch STORE, address, data, mask; loadRequest high (storeValid low) -> latch LOAD, address; counter := LATENCY-1; go BUSY if LATENCY>1, else DONE.
REQ-017 Store SHALL take priority when storeValid and loadRequest are both high in IDLE.
REQ-018 BUSY: counter decrements each cycle; at 0 go DONE.
REQ-019 Load data SHALL be read from the array on the edge entering DONE and held in a register.
REQ-020 DONE: drive loadDataValid=1 (LOAD) or storeComplete=1 (STORE) combinationally from state for exactly one cycle, then go IDLE.
REQ-021 Store SHALL write the array on the edge ending the DONE cycle, writing only enabled bytes; mask 4'b0000 writes nothing but still completes.
REQ-022 First response SHALL appear LATENCY cycles after the IDLE cycle in which the request was sampled; back-to-back accesses incur one IDLE cycle between responses.
REQ-023 LOAD in BUSY with loadRequest low (flush) SHALL abort to IDLE with no pulse; stores SHALL never abort.
REQ-024 Word index = (addressRegister - BASE_ADDRESS) >> 2; address bits [1:0] ignored.
REQ-025 loadData SHALL read 32'h0 in every cycle where loadDataValid is low.
REQ-026 A load issued immediately after a completed store to the same word SHALL return the post-store value.

Reset
REQ-027 reset low SHALL force IDLE, counter 0, loadDataValid=0, storeComplete=0, accessFault=0, loadData=0 immediately; array contents are not cleared.
REQ-028 Reset asserted mid-access SHALL discard the access with no pulse and no array write.

Configuration
REQ-029 Macro DATA_MEMORY_FAULT_EN defined: address outside [BASE_ADDRESS, BASE_ADDRESS+4*DEPTH_WORDS) SHALL complete normally with accessFault=1, store suppressed, loadData=0.
REQ-030 Macro undefined: word index wraps modulo DEPTH_WORDS and accessFault SHALL be tied 0.

Structure
REQ-031 Enum dataMemoryState_ (IDLE/BUSY/DONE) and access-kind enum SHALL live in package pack.
REQ-032 Storage SHALL be sub-module data_memory_array: DEPTH_WORDS x 32, one read port registered, one byte-masked write port.

Verification
REQ-033 LATENCY=2, store 32'hDEADBEEF mask 4'b1111 to 0x40, then load 0x40 -> storeComplete 2 cycles after acceptance, loadData=32'hDEADBEEF with loadDataValid 2 cycles after its acceptance.
REQ-034 Store 32'h0000AB00 mask 4'b0010 to 0x41 over word 32'h11223344 -> load 0x40 returns 32'h1122AB44.
REQ-035 storeValid and loadRequest both rise same cycle -> storeComplete first, loadDataValid one IDLE cycle plus LATENCY later.
REQ-036 LATENCY=4, loadRequest dropped after 2 cycles -> no loadDataValid, FSM back in IDLE next cycle.
REQ-037 FAULT_EN, DEPTH_WORDS=16, store to 0x80 then load 0x80 -> both pulses with accessFault=1, loadData=0; without macro, load 0x80 returns word at 0x00.
REQ-038 reset driven low in BUSY of a store to 0x10 -> outputs 0 same cycle, no storeComplete, word 0x10 unchanged.

Source files
------------

// File: rtl/data_memory_pkg.sv
// ---------------------------------------------------------------------------
// pack -- shared types for the data_memory block.
//   dataMemoryState_  : controller states IDLE / BUSY / DONE
//   dataMemoryAccess_ : kind of access latched at acceptance (LOAD / STORE)
// ---------------------------------------------------------------------------
package pack;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dataMemoryState_;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } dataMemoryAccess_;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/data_memory_if.sv
// ---------------------------------------------------------------------------
// data_memory_if -- load/store bus between an initiator and data_memory.
//   master : initiator side (drives requests, receives responses)
//   slave  : memory side
// Signals:
//   loadRequest         level load request, held until loadDataValid or flush
//   storeValid          store request, held until storeComplete
//   addressRegister     byte address of the access
//   storeData           lane-aligned store data
//   realStoreByteEnable per-byte store mask (bit i -> storeData[8i+7:8i])
//   loadData            loaded word, zero whenever loadDataValid is low
//   loadDataValid       one-cycle load response
//   storeComplete       one-cycle store acknowledge
//   accessFault         flags an out-of-range access alongside its response
// ---------------------------------------------------------------------------
interface data_memory_if;

  logic        loadRequest;
  logic        storeValid;
  logic [31:0] addressRegister;
  logic [31:0] storeData;
  logic [3:0]  realStoreByteEnable;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        accessFault;

  modport master (
    output loadRequest, storeValid, addressRegister, storeData, realStoreByteEnable,
    input  loadData, loadDataValid, storeComplete, accessFault
  );

  modport slave (
    input  loadRequest, storeValid, addressRegister, storeData, realStoreByteEnable,
    output loadData, loadDataValid, storeComplete, accessFault
  );

endinterface

// File: rtl/data_memory_array.sv
// ---------------------------------------------------------------------------
// data_memory_array -- DEPTH_WORDS x 32 storage.
//   One registered read port (readEnable/readIndex -> readData next edge)
//   and one byte-masked write port (writeEnable/writeIndex/writeData/writeMask).
// Ports: clock, reset (async active-low, clears only the read register).
// ---------------------------------------------------------------------------
module data_memory_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int INDEX_WIDTH = $clog2(DEPTH_WORDS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   readEnable,
  input  logic [INDEX_WIDTH-1:0] readIndex,
  output logic [31:0]            readData,
  input  logic                   writeEnable,
  input  logic [INDEX_WIDTH-1:0] writeIndex,
  input  logic [31:0]            writeData,
  input  logic [3:0]             writeMask
);

  logic [31:0] memory [DEPTH_WORDS];

  // NOTE: the storage array has no reset; clearing it would defeat RAM
  // inference and its contents must survive reset anyway.
  always_ff @(posedge clock) begin
    if (writeEnable) begin
      for (int b = 0; b < 4; b++) begin
        if (writeMask[b]) memory[writeIndex][8*b +: 8] <= writeData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          readData <= '0;
    else if (readEnable) readData <= memory[readIndex];
  end

endmodule

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory -- fixed-latency word memory with a load/store request bus.
//   A request sampled in IDLE is answered LATENCY cycles later by a one-cycle
//   loadDataValid or storeComplete pulse in DONE. Stores win over loads when
//   both are requested; a load whose request drops while BUSY is discarded.
// Parameters: DEPTH_WORDS (power of two), LATENCY (1..15), BASE_ADDRESS.
// Ports: clock, reset (async active-low), bus (data_memory_if.slave).
// Build option: define DATA_MEMORY_FAULT_EN to flag out-of-range accesses
//   with accessFault (store suppressed, loadData 0); otherwise the word
//   index wraps modulo DEPTH_WORDS and accessFault is tied low.
// ---------------------------------------------------------------------------
module data_memory
  import pack::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter int          LATENCY      = 2,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset,
  data_memory_if.slave bus
);

  localparam int         INDEX_WIDTH = $clog2(DEPTH_WORDS);
  localparam logic [3:0] COUNT_START = 4'(LATENCY - 1);

  dataMemoryState_        state, stateNext;
  dataMemoryAccess_       kind;
  logic [3:0]             counter;
  logic [INDEX_WIDTH-1:0] index, requestIndex, readIndex;
  logic [31:0]            storeDataQ, readData;
  logic [3:0]             maskQ;
  logic                   readEnable, writeEnable, faultActive;

  // Word offset from the base; the cast drops the high bits, giving the wrap.
  assign requestIndex = INDEX_WIDTH'((bus.addressRegister - BASE_ADDRESS) >> 2);

`ifdef DATA_MEMORY_FAULT_EN
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  logic faultQ;

  // 33-bit difference: addresses below the base go negative and fail too.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) faultQ <= 1'b0;
    else if (state == IDLE && (bus.storeValid || bus.loadRequest))
      faultQ <= ({1'b0, bus.addressRegister} - {1'b0, BASE_ADDRESS}) >= SPAN_BYTES;
  end

  assign faultActive = faultQ;
`else
  assign faultActive = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic. The counter starts at LATENCY-1 in the first BUSY cycle;
  // the cycle in which it would decrement to 0 is the last BUSY cycle.
  always_comb begin
    // NOTE: default first so no path through the case leaves stateNext
    // unassigned and infers a latch.
    stateNext = state;
    unique case (state)
      IDLE: if (bus.storeValid || bus.loadRequest) stateNext = (LATENCY > 1) ? BUSY : DONE;
      BUSY: begin
        if (kind == LOAD && !bus.loadRequest) stateNext = IDLE;
        else if (counter == 4'd1)             stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request capture and latency counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      kind       <= LOAD;
      counter    <= '0;
      index      <= '0;
      storeDataQ <= '0;
      maskQ      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.storeValid) begin
            kind       <= STORE;
            index      <= requestIndex;
            storeDataQ <= bus.storeData;
            maskQ      <= bus.realStoreByteEnable;
            counter    <= COUNT_START;
          end else if (bus.loadRequest) begin
            kind    <= LOAD;
            index   <= requestIndex;
            counter <= COUNT_START;
          end
        end
        BUSY:    counter <= counter - 4'd1;
        default: ;
      endcase
    end
  end

  // Read on the edge entering DONE; with LATENCY=1 that edge is the IDLE one,
  // so the index comes straight from the bus.
  assign readEnable  = (stateNext == DONE) && (state != DONE);
  assign readIndex   = (state == IDLE) ? requestIndex : index;
  // Write on the edge ending DONE, after the response has been signalled.
  assign writeEnable = (state == DONE) && (kind == STORE) && !faultActive;

  data_memory_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_array (
    .clock      (clock),
    .reset      (reset),
    .readEnable (readEnable),
    .readIndex  (readIndex),
    .readData   (readData),
    .writeEnable(writeEnable),
    .writeIndex (index),
    .writeData  (storeDataQ),
    .writeMask  (maskQ)
  );

  // Outputs decoded from state only, so reset clears them immediately.
  always_comb begin
    bus.loadDataValid = (state == DONE) && (kind == LOAD);
    bus.storeComplete = (state == DONE) && (kind == STORE);
    bus.accessFault   = (state == DONE) && faultActive;
    bus.loadData      = (bus.loadDataValid && !faultActive) ? readData : 32'h0;
  end

endmodule

// File: tb/tb_data_memory.sv
// ---------------------------------------------------------------------------
// tb_data_memory -- self-checking bench for data_memory.
//   dutA: DEPTH_WORDS=4096, LATENCY=2; dutB: DEPTH_WORDS=16, LATENCY=4.
//   Expected values come from a word-array model updated per byte mask.
//   Honours DATA_MEMORY_FAULT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_data_memory;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_memory_if busA ();
  data_memory_if busB ();

  data_memory #(.DEPTH_WORDS(4096), .LATENCY(2), .BASE_ADDRESS(32'h0)) dutA (
    .clock(clock), .reset(reset), .bus(busA.slave));
  data_memory #(.DEPTH_WORDS(16), .LATENCY(4), .BASE_ADDRESS(32'h0)) dutB (
    .clock(clock), .reset(reset), .bus(busB.slave));

  typedef struct packed {
    logic        v;
    logic        c;
    logic        f;
    logic [31:0] d;
  } obs_t;

  int nChecks = 0;
  int nFail   = 0;
  bit [31:0] modelA [int];
  bit [31:0] modelB [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit outOfRange(input int w, input logic [31:0] a);
`ifdef DATA_MEMORY_FAULT_EN
    return (w == 0) ? (a >= 32'h4000) : (a >= 32'd64);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int wordOf(input int w, input logic [31:0] a);
    return (w == 0) ? int'((a >> 2) % 4096) : int'((a >> 2) % 16);
  endfunction

  function automatic logic [31:0] modelRead(input int w, input logic [31:0] a);
    int i = wordOf(w, a);
    if (outOfRange(w, a)) return 32'h0;
    if (w == 0) return modelA.exists(i) ? modelA[i] : 32'h0;
    return modelB.exists(i) ? modelB[i] : 32'h0;
  endfunction

  task automatic modelWrite(input int w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m);
    logic [31:0] word;
    int i = wordOf(w, a);
    if (outOfRange(w, a)) return;
    word = modelRead(w, a);
    for (int b = 0; b < 4; b++) if (m[b]) word[8*b +: 8] = d[8*b +: 8];
    if (w == 0) modelA[i] = word; else modelB[i] = word;
  endtask

  // ---- bus helpers ----
  task automatic drive(input int w, input bit ld, input bit st, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    if (w == 0) begin
      busA.loadRequest = ld; busA.storeValid = st; busA.addressRegister = a;
      busA.storeData = d; busA.realStoreByteEnable = m;
    end else begin
      busB.loadRequest = ld; busB.storeValid = st; busB.addressRegister = a;
      busB.storeData = d; busB.realStoreByteEnable = m;
    end
  endtask

  function automatic obs_t sample(input int w);
    obs_t s;
    if (w == 0) begin
      s.v = busA.loadDataValid; s.c = busA.storeComplete; s.f = busA.accessFault; s.d = busA.loadData;
    end else begin
      s.v = busB.loadDataValid; s.c = busB.storeComplete; s.f = busB.accessFault; s.d = busB.loadData;
    end
    return s;
  endfunction

  // One complete access: issue, count cycles to the response, check it and
  // the quiet cycle that follows.
  task automatic runAccess(input int w, input bit st, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, input string tag, output logic [31:0] rd);
    int n = 0;
    bit got = 0;
    obs_t s;
    int lat = (w == 0) ? 2 : 4;
    logic [31:0] expData = modelRead(w, a);
    @(posedge clock); #1;
    drive(w, !st, st, a, d, m);
    while (!got && n < 40) begin
      @(negedge clock);
      s = sample(w);
      if ((st && s.c) || (!st && s.v)) got = 1;
      else begin
        check({tag, " early pulse"}, 32'({s.v, s.c, s.f}), 32'h0);
        check({tag, " idle data"}, s.d, 32'h0);
        n++;
      end
    end
    check({tag, " latency"}, n, lat);
    check({tag, " fault"}, 32'(s.f), 32'(outOfRange(w, a)));
    check({tag, " other pulse"}, 32'(st ? s.v : s.c), 32'h0);
    if (!st) check({tag, " data"}, s.d, expData);
    rd = s.d;
    @(posedge clock); #1;
    drive(w, 0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clock);
    s = sample(w);
    check({tag, " single cycle"}, 32'({s.v, s.c, s.f}), 32'h0);
    check({tag, " data after"}, s.d, 32'h0);
    if (st) modelWrite(w, a, d, m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    obs_t s;
    int n;
    bit got;

    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    #2 reset = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      s = sample(w);
      check("reset pulses", 32'({s.v, s.c, s.f}), 32'h0);
      check("reset data", s.d, 32'h0);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Store then load, LATENCY=2.
    runAccess(0, 1, 32'h40, 32'hDEADBEEF, 4'hF, "st40", rd);
    runAccess(0, 0, 32'h40, 32'h0, 4'h0, "ld40", rd);
    check("ld40 literal", rd, 32'hDEADBEEF);

    // Single-byte store into an existing word.
    runAccess(0, 1, 32'h40, 32'h11223344, 4'hF, "st40 base", rd);
    runAccess(0, 1, 32'h41, 32'h0000AB00, 4'b0010, "st41 byte1", rd);
    runAccess(0, 0, 32'h40, 32'h0, 4'h0, "ld40 merged", rd);
    check("merged literal", rd, 32'h1122AB44);

    // Empty mask completes but writes nothing.
    runAccess(0, 1, 32'h40, 32'hFFFFFFFF, 4'h0, "st mask0", rd);
    runAccess(0, 0, 32'h40, 32'h0, 4'h0, "ld mask0", rd);

    // Store and load requested together: store first, load after one IDLE.
    @(posedge clock); #1;
    drive(0, 1, 1, 32'h44, 32'hCAFE0001, 4'hF);
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clock); s = sample(0);
      if (s.c) got = 1; else n++;
    end
    check("both: store latency", n, 2);
    check("both: no load yet", 32'(s.v), 32'h0);
    @(posedge clock); #1;
    drive(0, 1, 0, 32'h44, 32'h0, 4'h0);
    modelWrite(0, 32'h44, 32'hCAFE0001, 4'hF);
    n = 1; got = 0;
    while (!got && n < 40) begin
      @(negedge clock); s = sample(0);
      if (s.v) got = 1; else n++;
    end
    check("both: load after store", n, 3);
    check("both: load data", s.d, modelRead(0, 32'h44));
    @(posedge clock); #1;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Randomized traffic on dutA, including wrapping/out-of-range addresses.
    for (int i = 0; i < 8; i++) runAccess(0, 1, 32'(i * 4), $urandom, 4'hF, "init", rd);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a + 32'h4000;
      runAccess(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand", rd);
    end

    // LATENCY=4 store/load on dutB.
    runAccess(1, 1, 32'h10, 32'h0F0F1234, 4'hF, "B st10", rd);
    runAccess(1, 0, 32'h10, 32'h0, 4'h0, "B ld10", rd);

    // Flush: load held for two cycles, then withdrawn while BUSY.
    @(posedge clock); #1;
    drive(1, 1, 0, 32'h10, 32'h0, 4'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); s = sample(1);
      check("flush no pulse", 32'({s.v, s.c}), 32'h0);
    end
    runAccess(1, 0, 32'h10, 32'h0, 4'h0, "B after flush", rd);

    // Out-of-range handling on the 16-word dutB.
    runAccess(1, 1, 32'h00, 32'h5A5A5A5A, 4'hF, "B st00", rd);
    runAccess(1, 1, 32'h80, 32'h12345678, 4'hF, "B st80", rd);
    runAccess(1, 0, 32'h80, 32'h0, 4'h0, "B ld80", rd);
`ifdef DATA_MEMORY_FAULT_EN
    check("B ld80 literal", rd, 32'h0);
`else
    check("B ld80 literal", rd, 32'h12345678);
`endif
    runAccess(1, 0, 32'h00, 32'h0, 4'h0, "B ld00", rd);

    // Reset during a BUSY store: no acknowledge, no write.
    @(posedge clock); #1;
    drive(1, 0, 1, 32'h10, 32'h0BAD0BAD, 4'hF);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    s = sample(1);
    check("rst store pulses", 32'({s.v, s.c, s.f}), 32'h0);
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clock); reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); s = sample(1);
      check("rst store no ack", 32'(s.c), 32'h0);
    end
    runAccess(1, 0, 32'h10, 32'h0, 4'h0, "B ld10 kept", rd);

    // Reset during a DONE load response clears outputs at once.
    @(posedge clock); #1;
    drive(0, 1, 0, 32'h44, 32'h0, 4'h0);
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clock); s = sample(0);
      if (s.v) got = 1; else n++;
    end
    check("rst done latency", n, 2);
    #1 reset = 1'b0;
    #1 s = sample(0);
    check("rst done pulses", 32'({s.v, s.c, s.f}), 32'h0);
    check("rst done data", s.d, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clock); reset = 1'b1;
    runAccess(0, 0, 32'h44, 32'h0, 4'h0, "ld44 after rst", rd);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
